// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides and an iterative
// shift-add multiplier; one operation in flight, result held until accepted.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               carry,
  output logic               ovf,
  output logic               zero
);

  localparam int RW  = 2 * WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_XOR = 3'd3,
    OP_AND = 3'd4, OP_OR  = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Single-cycle ops; returns {carry, ovf, y}. MUL is handled by the engine.
  function automatic logic [RW+1:0] alu_eval(input alu_op_e f_op,
                                             input logic [WIDTH-1:0] fa,
                                             input logic [WIDTH-1:0] fb);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [RW-1:0]    a_ext;
    logic [SHW-1:0]   sh;
    logic [RW-1:0]    r_y;
    logic             r_c;
    logic             r_o;
    sum   = {1'b0, fa} + {1'b0, fb};
    diff  = fa - fb;
    a_ext = {{WIDTH{1'b0}}, fa};
    sh    = fb[SHW-1:0];
    r_y   = '0;
    r_c   = 1'b0;
    r_o   = 1'b0;
    case (f_op)
      OP_ADD: begin
        r_y = {{(WIDTH-1){1'b0}}, sum};
        r_c = sum[WIDTH];
        r_o = (fa[WIDTH-1] == fb[WIDTH-1]) && (sum[WIDTH-1] != fa[WIDTH-1]);
      end
      OP_SUB: begin
        r_y = {{WIDTH{1'b0}}, diff};
        r_c = (fa < fb);
        r_o = (fa[WIDTH-1] != fb[WIDTH-1]) && (diff[WIDTH-1] != fa[WIDTH-1]);
      end
      OP_XOR:  r_y = {{WIDTH{1'b0}}, fa ^ fb};
      OP_AND:  r_y = {{WIDTH{1'b0}}, fa & fb};
      OP_OR:   r_y = {{WIDTH{1'b0}}, fa | fb};
      OP_SHL:  r_y = a_ext << sh;
      OP_SHR:  r_y = a_ext >> sh;
      default: r_y = '0;
    endcase
    return {r_c, r_o, r_y};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    y_q, y_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic [RW+1:0]    eval_s;
  logic [RW-1:0]    partial_s;
  logic [RW-1:0]    acc_sum_s;

  assign in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign is_mul_s   = (alu_op_e'(op) == OP_MUL);

  // Next-state, operand capture, multiply step and result/flag update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    y_d         = y_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    eval_s      = alu_eval(alu_op_e'(op), a, b);
    partial_s   = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_sum_s   = acc_q + partial_s;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          a_d = a;
          b_d = b;
          if (is_mul_s) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = S_DONE;
            y_d     = eval_s[RW-1:0];
            ovf_d   = eval_s[RW];
            carry_d = eval_s[RW+1];
            zero_d  = (eval_s[RW-1:0] == '0);
          end
        end else if ((state_q == S_DONE) && !out_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = acc_sum_s;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          y_d     = acc_sum_s;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (acc_sum_s == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
